// File: rtl/nand_seq_ctrl.sv
// Bit-serial logic unit: every result bit is built from a short sequence of
// evaluations of one shared 2-input NAND cell, one evaluation per clock.
module nand_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned STEP_W = 3;

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T, SRC_U, SRC_V, SRC_YP} src_t;
    typedef enum logic [2:0] {DST_T, DST_U, DST_V, DST_YP, DST_Y} dst_t;

    state_t              state, state_nx;
    logic [WIDTH-1:0]    a_q, b_q, a_nx, b_nx, y_nx;
    logic [2:0]          op_q, op_nx;
    logic [IDX_W-1:0]    bit_idx, bit_nx;
    logic [STEP_W-1:0]   step, step_nx, step_last;
    logic                t_q, u_q, v_q, yp_q, t_nx, u_nx, v_nx, yp_nx;
    logic                busy_nx, done_nx, err_nx;
    logic                accept, illegal, last_step, last_bit;
    src_t                src0, src1;
    dst_t                dst;
    logic                nand_x0, nand_x1, nand_y;

    assign last_step = (step == step_last);
    assign last_bit  = (bit_idx == IDX_W'(WIDTH - 1));

    // Step microcode: operand sources and destination for the current step
    always_comb begin
        src0      = SRC_A;
        src1      = SRC_B;
        dst       = DST_Y;
        step_last = STEP_W'(0);
        case (op_q)
            OP_NOT: src1 = SRC_A;
            OP_AND: begin
                step_last = STEP_W'(1);
                if (step == STEP_W'(0)) dst = DST_T;
                else begin src0 = SRC_T; src1 = SRC_T; end
            end
            OP_OR, OP_NOR: begin
                step_last = (op_q == OP_OR) ? STEP_W'(2) : STEP_W'(3);
                case (step)
                    STEP_W'(0): begin src1 = SRC_A; dst = DST_T; end
                    STEP_W'(1): begin src0 = SRC_B; dst = DST_U; end
                    STEP_W'(2): begin
                        src0 = SRC_T; src1 = SRC_U;
                        dst  = (op_q == OP_OR) ? DST_Y : DST_YP;
                    end
                    default:    begin src0 = SRC_YP; src1 = SRC_YP; end
                endcase
            end
            OP_XOR, OP_XNOR: begin
                step_last = (op_q == OP_XOR) ? STEP_W'(3) : STEP_W'(4);
                case (step)
                    STEP_W'(0): dst = DST_T;
                    STEP_W'(1): begin src1 = SRC_T; dst = DST_U; end
                    STEP_W'(2): begin src0 = SRC_B; src1 = SRC_T; dst = DST_V; end
                    STEP_W'(3): begin
                        src0 = SRC_U; src1 = SRC_V;
                        dst  = (op_q == OP_XOR) ? DST_Y : DST_YP;
                    end
                    default:    begin src0 = SRC_YP; src1 = SRC_YP; end
                endcase
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; an illegal op goes straight to DONE with err
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        illegal  = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start) begin
                    if (op == OP_ILL) begin
                        illegal  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        accept   = 1'b1;
                        state_nx = EXEC;
                    end
                end
            end
            EXEC:    if (last_step && last_bit) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Output/datapath logic around the single NAND cell
    always_comb begin
        a_nx    = a_q;
        b_nx    = b_q;
        op_nx   = op_q;
        bit_nx  = bit_idx;
        step_nx = step;
        t_nx    = t_q;
        u_nx    = u_q;
        v_nx    = v_q;
        yp_nx   = yp_q;
        y_nx    = y;
        err_nx  = 1'b0;
        busy_nx = (state_nx == EXEC);
        done_nx = (state_nx == DONE);

        case (src0)
            SRC_A:   nand_x0 = a_q[bit_idx];
            SRC_B:   nand_x0 = b_q[bit_idx];
            SRC_T:   nand_x0 = t_q;
            SRC_U:   nand_x0 = u_q;
            SRC_V:   nand_x0 = v_q;
            default: nand_x0 = yp_q;
        endcase
        case (src1)
            SRC_A:   nand_x1 = a_q[bit_idx];
            SRC_B:   nand_x1 = b_q[bit_idx];
            SRC_T:   nand_x1 = t_q;
            SRC_U:   nand_x1 = u_q;
            SRC_V:   nand_x1 = v_q;
            default: nand_x1 = yp_q;
        endcase
        nand_y = ~(nand_x0 & nand_x1);

        if (accept) begin
            a_nx    = a;
            b_nx    = b;
            op_nx   = op;
            bit_nx  = IDX_W'(0);
            step_nx = STEP_W'(0);
            t_nx    = 1'b0;
            u_nx    = 1'b0;
            v_nx    = 1'b0;
            yp_nx   = 1'b0;
        end else if (illegal) begin
            err_nx = 1'b1;
        end else if (state == EXEC) begin
            case (dst)
                DST_T:   t_nx  = nand_y;
                DST_U:   u_nx  = nand_y;
                DST_V:   v_nx  = nand_y;
                DST_YP:  yp_nx = nand_y;
                default: y_nx[bit_idx] = nand_y;
            endcase
            if (last_step) begin
                step_nx = STEP_W'(0);
                t_nx    = 1'b0;
                u_nx    = 1'b0;
                v_nx    = 1'b0;
                yp_nx   = 1'b0;
                if (!last_bit) bit_nx = bit_idx + IDX_W'(1);
            end else begin
                step_nx = step + STEP_W'(1);
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            bit_idx <= '0;
            step    <= '0;
            t_q     <= 1'b0;
            u_q     <= 1'b0;
            v_q     <= 1'b0;
            yp_q    <= 1'b0;
            y       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            a_q     <= a_nx;
            b_q     <= b_nx;
            op_q    <= op_nx;
            bit_idx <= bit_nx;
            step    <= step_nx;
            t_q     <= t_nx;
            u_q     <= u_nx;
            v_q     <= v_nx;
            yp_q    <= yp_nx;
            y       <= y_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            err     <= err_nx;
        end
    end

endmodule

// File: doc/nand_seq_ctrl.md
NAND_SEQ_CTRL -- requirements
Module: nand_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request new operation; sampled only in IDLE or DONE.
REQ-005 SHALL have port op  input  3  operation code, see REQ-011.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B (ignored for NOT).
REQ-008 SHALL have port busy  output  1  high while the operation executes.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports y  output  WIDTH  result register, and err  output  1  one-cycle illegal-op pulse.

Function
REQ-011 Op codes and NAND steps per bit (S) SHALL be: 000 NAND S=1; 001 AND S=2; 010 OR S=3; 011 NOR S=4; 100 XOR S=4; 101 XNOR S=5; 110 NOT A S=1; 111 illegal.
REQ-012 All logic evaluation SHALL use exactly one shared 2-input NAND cell, one evaluation per clock; no other logic gate SHALL compute result bits.
REQ-013 Step sequences SHALL be: NAND y=n(a,b); NOT y=n(a,a); AND t=n(a,b), y=n(t,t); OR t=n(a,a), u=n(b,b), y=n(t,u); NOR as OR then y=n(y',y'); XOR t=n(a,b), u=n(a,t), v=n(b,t), y=n(u,v); XNOR as XOR then y=n(y',y').
REQ-014 Scratch bits t,u,v and intermediate y' SHALL be internal registers, cleared at the start of each bit.
REQ-015 FSM states SHALL be IDLE, EXEC, DONE.
REQ-016 IDLE/DONE with start=1 and legal op SHALL latch a, b, op, zero the bit index and step counter, and enter EXEC next cycle.
REQ-017 EXEC SHALL process bit 0 first, steps 0..S-1 per bit, bit index incrementing after step S-1; result bit SHALL be written into y[bit] on its final step.
REQ-018 EXEC SHALL last exactly WIDTH*S cycles, then enter DONE; busy SHALL be 1 in every EXEC cycle and 0 otherwise.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE unless a new start is accepted (REQ-016).
REQ-020 Latency from start-accept edge to done=1 SHALL be WIDTH*S+1 cycles (WIDTH=8 AND: 17).
REQ-021 start during EXEC SHALL be ignored; a, b, op changes during EXEC SHALL NOT affect the result.
REQ-022 y bits not yet written in EXEC SHALL hold previous values; y SHALL hold final result until the next accepted operation writes it.
REQ-023 start with op=111 in IDLE/DONE SHALL pulse err=1 and done=1 together on the next cycle, not enter EXEC, leave y unchanged.
REQ-024 Bit index and step counter SHALL be sized to WIDTH and 3 bits respectively and never wrap inside an operation.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, y=0, busy=0, done=0, err=0, counters and scratch to 0, regardless of state.
REQ-026 rst asserted mid-EXEC SHALL abort the operation with no done pulse; rst SHALL take priority over start.
REQ-027 First start after rst deassertion SHALL be accepted on the first edge with rst=0.

Verification
REQ-028 WIDTH=8, op=001, a=0xF0, b=0xCC, start 1 cycle -> busy 16 cycles, done at cycle 17, y=0xC0, err=0.
REQ-029 op=100, a=0xA5, b=0x0F -> done at cycle 33, y=0xAA; then op=101 same operands started in DONE cycle -> done 41 cycles later, y=0x55.
REQ-030 op=111 from IDLE -> err=1 and done=1 for one cycle, busy stays 0, y unchanged.
REQ-031 op=010 a=0x00 b=0x00 started, rst=1 at cycle 10 -> next cycle y=0, busy=0, no done; restart op=000 a=0xFF b=0x0F -> done at cycle 9, y=0xF0.
REQ-032 During op=011 execution, toggle start/a/b/op every cycle -> single done at cycle 33, y=~(a|b) from latched operands.
REQ-033 Sweep all legal ops over 256 random operand pairs, WIDTH=8 and WIDTH=1 -> y matches bitwise reference, latency per REQ-020.
